// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: m0 (display fetch) and m1 (CPU) share one slave port.
// Latency: grant one clk after cyc is sampled in IDLE; slave signals muxed combinationally.
// Backpressure: losers wait for IDLE, slave stall ends in err after TIMEOUT waits.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (display fetch)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:2] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1 (CPU)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:2] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // shared slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:2] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state;
  logic        last_gnt;   // 0: m0 won the last grant, 1: m1 did
  logic        lock0;      // m0 timed out and has not yet released cyc
  logic        lock1;
  logic [15:0] wait_cnt;

  logic        sel0;
  logic        sel1;
  logic        mux_cyc;
  logic        mux_stb;
  logic        timeout_hit;
  logic        req0;
  logic        req1;

  assign gnt_o = {state == GNT1, state == GNT0};

  // Only an eligible (not locked-out) master may win arbitration.
  assign req0 = m0_cyc_i & ~lock0;
  assign req1 = m1_cyc_i & ~lock1;

  // Route the granted master onto the slave port; everything is zero in IDLE and while rst is held.
  always_comb begin
    sel0     = (state == GNT0) && !rst;
    sel1     = (state == GNT1) && !rst;
    mux_cyc  = 1'b0;
    mux_stb  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    s_sel_o  = '0;
    s_data_o = '0;
    if (sel0) begin
      mux_cyc  = m0_cyc_i;
      mux_stb  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
      s_sel_o  = m0_sel_i;
      s_data_o = m0_data_i;
    end else if (sel1) begin
      mux_cyc  = m1_cyc_i;
      mux_stb  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_cti_o  = m1_cti_i;
      s_bte_o  = m1_bte_i;
      s_sel_o  = m1_sel_i;
      s_data_o = m1_data_i;
    end
  end

  // A stalled strobe reaching TIMEOUT wait cycles is cut off; a slave response in that cycle wins.
  assign timeout_hit = (sel0 | sel1) & mux_stb & (wait_cnt == TIMEOUT_CNT) & ~s_ack_i & ~s_err_i;

  assign s_cyc_o = mux_cyc & ~timeout_hit;
  assign s_stb_o = mux_stb & ~timeout_hit;

  // Return path: only the granted master sees data and terminations.
  always_comb begin
    m0_data_o = sel0 ? s_data_i : 32'd0;
    m1_data_o = sel1 ? s_data_i : 32'd0;
    m0_ack_o  = sel0 & s_ack_i;
    m1_ack_o  = sel1 & s_ack_i;
    m0_err_o  = sel0 & (s_err_i | timeout_hit);
    m1_err_o  = sel1 & (s_err_i | timeout_hit);
  end

  // Grant FSM, tie-break history, stall counter and timeout lockouts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      wait_cnt <= 16'd0;
      lock0    <= 1'b0;
      lock1    <= 1'b0;
    end else begin
      if (state == IDLE || !s_stb_o || s_ack_i || s_err_i)
        wait_cnt <= 16'd0;
      else
        wait_cnt <= wait_cnt + 16'd1;

      if (timeout_hit && state == GNT0)
        lock0 <= 1'b1;
      else if (!m0_cyc_i)
        lock0 <= 1'b0;

      if (timeout_hit && state == GNT1)
        lock1 <= 1'b1;
      else if (!m1_cyc_i)
        lock1 <= 1'b0;

      case (state)
        IDLE: begin
          if (req0 && req1) begin
            if (last_gnt == 1'b0) begin
              state    <= GNT1;
              last_gnt <= 1'b1;
            end else begin
              state    <= GNT0;
              last_gnt <= 1'b0;
            end
          end else if (req0) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
          end else if (req1) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
          end
        end
        GNT0: begin
          if (timeout_hit || !m0_cyc_i)
            state <= IDLE;
        end
        GNT1: begin
          if (timeout_hit || !m1_cyc_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with TIMEOUT=4.
// Inputs change 1 ns after the rising edge, outputs are checked 2 ns after it.
// Each scenario starts from a synchronous reset.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:2] m0_addr_i;
  logic [2:0]  m0_cti_i;
  logic [1:0]  m0_bte_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:2] m1_addr_i;
  logic [2:0]  m1_cti_i;
  logic [1:0]  m1_bte_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:2] s_addr_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_data_o, s_data_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  gnt_o;

  int n_vec = 0;
  int n_err = 0;

  wb_arbiter_2m #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
    .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
    .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_sel_o(s_sel_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then changed at +1 and checked at +2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_cti_i = 0;
    m0_bte_i = 0; m0_sel_i = 0; m0_data_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_cti_i = 0;
    m1_bte_i = 0; m1_sel_i = 0; m1_data_i = 0;
    s_data_i = 0; s_ack_i = 0; s_err_i = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " gnt"}, {30'd0, gnt_o}, 32'd0);
    check({tag, " s_cyc"}, {31'd0, s_cyc_o}, 32'd0);
    check({tag, " acks"}, {28'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'd0);
  endtask

  initial begin
    // ---- reset state
    clear_inputs();
    rst = 1;
    m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;   // requests and acks are ignored while rst is held
    step(); settle();
    check_quiet("rst_hold");
    step(); settle();
    check_quiet("rst_hold2");
    do_reset();
    settle();
    check_quiet("post_rst");
    check("idle s_addr", {2'b0, s_addr_o}, 32'd0);

    // ---- m1 single read, ack on second strobe cycle
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 30'h0000_1234; m1_sel_i = 4'hF;
    settle();
    check("s1 gnt before edge", {30'd0, gnt_o}, 32'd0);
    check("s1 s_stb idle", {31'd0, s_stb_o}, 32'd0);
    step(); settle();
    check("s1 gnt", {30'd0, gnt_o}, 32'h2);
    check("s1 s_addr", {2'b0, s_addr_o}, 32'h0000_1234);
    check("s1 no ack yet", {31'd0, m1_ack_o}, 32'd0);
    step();
    s_ack_i = 1; s_data_i = 32'hCAFE_F00D;
    settle();
    check("s1 ack", {31'd0, m1_ack_o}, 32'd1);
    check("s1 data", m1_data_o, 32'hCAFE_F00D);
    check("s1 m0 data", m0_data_o, 32'd0);
    check("s1 m0 ack", {31'd0, m0_ack_o}, 32'd0);
    step();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    settle();
    check("s1 gnt held", {30'd0, gnt_o}, 32'h2);
    step(); settle();
    check("s1 gnt released", {30'd0, gnt_o}, 32'd0);

    // ---- simultaneous requests: m0 first, turnaround, then m1; tie-break alternates
    do_reset();
    m0_cyc_i = 1; m1_cyc_i = 1;
    step(); settle();
    check("s2 first gnt m0", {30'd0, gnt_o}, 32'h1);
    s_ack_i = 1;
    settle();
    check("s2 m0 ack", {31'd0, m0_ack_o}, 32'd1);
    check("s2 m1 no ack", {31'd0, m1_ack_o}, 32'd0);
    step();
    s_ack_i = 0; m0_cyc_i = 0;
    step(); settle();
    check("s2 turnaround idle", {30'd0, gnt_o}, 32'd0);
    step(); settle();
    check("s2 then m1", {30'd0, gnt_o}, 32'h2);
    m1_cyc_i = 0;
    step(); settle();
    check("s2 idle again", {30'd0, gnt_o}, 32'd0);
    m0_cyc_i = 1; m1_cyc_i = 1;
    step(); settle();
    check("s2 renewed tie m0", {30'd0, gnt_o}, 32'h1);
    m0_cyc_i = 0; m1_cyc_i = 0;
    step();
    step(); settle();
    check("s2 idle before tie", {30'd0, gnt_o}, 32'd0);
    m0_cyc_i = 1; m1_cyc_i = 1;
    step(); settle();
    check("s2 tie after m0 goes m1", {30'd0, gnt_o}, 32'h2);
    m0_cyc_i = 0; m1_cyc_i = 0;
    step();

    // ---- m0 8-beat incrementing burst with m1 waiting
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = 3'b010; m0_addr_i = 30'h100;
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    for (int b = 0; b < 8; b++) begin
      m0_addr_i = 30'h100 + 30'(b);
      m0_cti_i  = (b == 7) ? 3'b111 : 3'b010;
      s_ack_i   = 1; s_data_i = 32'hB000_0000 + 32'(b);
      settle();
      check($sformatf("s3 gnt beat%0d", b), {30'd0, gnt_o}, 32'h1);
      check($sformatf("s3 addr beat%0d", b), {2'b0, s_addr_o}, 32'h100 + 32'(b));
      check($sformatf("s3 cti beat%0d", b), {29'd0, s_cti_o}, (b == 7) ? 32'h7 : 32'h2);
      check($sformatf("s3 m0 data beat%0d", b), m0_data_o, 32'hB000_0000 + 32'(b));
      check($sformatf("s3 m1 ack beat%0d", b), {31'd0, m1_ack_o}, 32'd0);
      step();
    end
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = 0;
    step(); settle();
    check("s3 idle after burst", {30'd0, gnt_o}, 32'd0);
    step(); settle();
    check("s3 m1 granted", {30'd0, gnt_o}, 32'h2);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();

    // ---- timeout on m1, lockout while cyc held, regrant after cyc toggles
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    for (int w = 0; w < 4; w++) begin
      settle();
      check($sformatf("s4 wait%0d err", w), {31'd0, m1_err_o}, 32'd0);
      check($sformatf("s4 wait%0d s_stb", w), {31'd0, s_stb_o}, 32'd1);
      step();
    end
    settle();
    check("s4 timeout err", {31'd0, m1_err_o}, 32'd1);
    check("s4 timeout s_cyc", {31'd0, s_cyc_o}, 32'd0);
    check("s4 timeout s_stb", {31'd0, s_stb_o}, 32'd0);
    check("s4 timeout m0 err", {31'd0, m0_err_o}, 32'd0);
    step(); settle();
    check("s4 idle after timeout", {30'd0, gnt_o}, 32'd0);
    check("s4 err one cycle", {31'd0, m1_err_o}, 32'd0);
    step(); settle();
    check("s4 locked out", {30'd0, gnt_o}, 32'd0);
    step(); settle();
    check("s4 still locked out", {30'd0, gnt_o}, 32'd0);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    m1_cyc_i = 1;
    step(); settle();
    check("s4 regranted", {30'd0, gnt_o}, 32'h2);
    m1_cyc_i = 0;
    step();

    // ---- ack on the exact timeout cycle
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    repeat (4) step();
    s_ack_i = 1; s_data_i = 32'h1234_5678;
    settle();
    check("s6 ack wins", {31'd0, m0_ack_o}, 32'd1);
    check("s6 no err", {31'd0, m0_err_o}, 32'd0);
    check("s6 s_stb kept", {31'd0, s_stb_o}, 32'd1);
    step();
    s_ack_i = 0;
    settle();
    check("s6 grant kept", {30'd0, gnt_o}, 32'h1);
    check("s6 no err after", {31'd0, m0_err_o}, 32'd0);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();

    // ---- reset during an m0 burst
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = 3'b010;
    step();
    s_ack_i = 1;
    step(); settle();
    check("s5 bursting", {31'd0, m0_ack_o}, 32'd1);
    rst = 1;
    settle();
    check("s5 no ack in rst", {31'd0, m0_ack_o}, 32'd0);
    check("s5 no err in rst", {31'd0, m0_err_o}, 32'd0);
    step(); settle();
    check_quiet("s5 after rst");
    rst = 0;
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step(); settle();
    check("s5 stays idle", {30'd0, gnt_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: slave wait cycles without ack/err before forced termination (1..65535).
REQ-002 The block SHALL have port clk, input, 1: single clock for all logic.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports m0_cyc_i/m1_cyc_i, input, 1: master cycle request; m0 is display fetch, m1 is CPU.
REQ-005 The block SHALL have ports mX_stb_i and mX_we_i, input, 1 each: master strobe and write enable.
REQ-006 The block SHALL have ports mX_addr_i, input, [31:2]: master word address.
REQ-007 The block SHALL have ports mX_cti_i [2:0], mX_bte_i [1:0] and mX_sel_i [3:0], all inputs: burst type, burst extension and byte select.
REQ-008 The block SHALL have ports mX_data_i, input, 32: master write data.
REQ-009 The block SHALL have ports mX_data_o, output, 32: read data, valid when mX_ack_o is high.
REQ-010 The block SHALL have ports mX_ack_o and mX_err_o, output, 1 each: per-master termination.
REQ-011 The block SHALL have ports s_cyc_o, s_stb_o, s_we_o, s_addr_o [31:2], s_cti_o, s_bte_o, s_sel_o and s_data_o, all outputs: shared slave side.
REQ-012 The block SHALL have ports s_data_i (32), s_ack_i and s_err_i, all inputs: slave response.
REQ-013 The block SHALL have port gnt_o, output, [1:0]: one-hot current grant; 00 means idle.

Function
REQ-014 The FSM SHALL have states IDLE, GNT0 and GNT1, held in registers; gnt_o SHALL equal {state==GNT1, state==GNT0}.
REQ-015 IDLE SHALL transition on the next clk edge after a cyc is sampled high: to GNT0 if only m0 requests, to GNT1 if only m1 requests.
REQ-016 When both m0 and m1 request in IDLE, the block SHALL go to GNT0 unless the last_gnt register equals 0, in which case it SHALL go to GNT1 (alternation prevents CPU starvation).
REQ-017 last_gnt SHALL update on every IDLE exit.
REQ-018 GNTx SHALL persist while mX_cyc_i is high, including across multi-beat bursts (cti 010), and SHALL return to IDLE on the edge where mX_cyc_i is sampled low.
REQ-019 There SHALL be no direct GNTx-to-GNTy transition; IDLE always lasts at least 1 cycle, giving 1 cycle bus turnaround.
REQ-020 In GNTx, the s_* outputs SHALL be combinationally muxed from master X, mX_data_o SHALL equal s_data_i, and mX_ack_o/mX_err_o SHALL follow s_ack_i/s_err_i.
REQ-021 The non-granted master SHALL see ack=0 and err=0, and its data_o SHALL be 0.
REQ-022 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and the other s_* outputs SHALL be 0.
REQ-023 A 16-bit wait counter SHALL clear when state is not GNTx, when s_stb_o is 0, or when s_ack_i or s_err_i is high, and SHALL otherwise increment by 1 per cycle.
REQ-024 When the wait counter equals TIMEOUT, the block SHALL assert mX_err_o for exactly 1 cycle, drive s_cyc_o and s_stb_o to 0 in that cycle, and enter IDLE on the next edge, whether or not the master still holds cyc.
REQ-025 A timed-out master SHALL NOT be regranted until it has dropped cyc for at least 1 cycle (a per-master lockout flag is set on timeout and cleared when cyc_i is low).
REQ-026 If s_ack_i and the timeout coincide, ack SHALL win: no err, and the counter clears.
REQ-027 Requests arriving mid-grant SHALL wait; they SHALL NOT preempt an active grant.

Reset
REQ-028 Reset SHALL be synchronous and active-high; rst high at a clk edge SHALL force state IDLE, last_gnt=1 (so m0 wins the first tie), wait counter 0 and lockout flags 0.
REQ-029 During and after reset, all outputs SHALL be 0 (gnt_o=00, s_cyc_o=0, and all ack/err=0).
REQ-030 Reset asserted mid-burst SHALL abort the burst with no err pulse.

Verification
REQ-031 Scenario: m1 single read only, slave acks on 2nd cycle of stb -> gnt_o 00→10 one cycle after cyc, m1_ack_o=1 with m1_data_o=s_data_i, gnt_o returns to 00 one cycle after cyc drops.
REQ-032 Scenario: m0 and m1 both assert cyc from IDLE after reset -> GNT0 first; after m0 drops cyc, 1 IDLE cycle, then GNT1; a renewed simultaneous request then goes to m0.
REQ-033 Scenario: m0 8-beat incrementing burst (cti 010, final beat 111) while m1 requests -> no grant change until m0 cyc low; m1 never sees ack.
REQ-034 Scenario: TIMEOUT=4, slave never acks m1 -> m1_err_o pulses 1 cycle at the 4th wait cycle, IDLE follows, m1 is not regranted while cyc is held, and is granted after cyc toggles low then high.
REQ-035 Scenario: rst asserted during GNT0 burst -> next cycle gnt_o=00 and s_cyc_o=0, no ack or err on either master.
REQ-036 Scenario: ack arriving exactly on the TIMEOUT cycle -> ack passed through, err stays 0.
